store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Receiving end of the ROB's committed-store port. Accepts one retired store per cycle (address and data), queues it in order, and drains it to the data cache over a req/ack handshake.
- Drives the store stall back to the ROB. While full, the ROB holds the store at its head.
- Provides combinational store-to-load forwarding for loads whose address matches a buffered store that has not yet been written.

Parameters:
- SB_DEPTH, 4, number of buffered committed stores; must be a power of 2 and at least 2.
- ADDR_WIDTH, 26, word address width; same as the core's ADDR_WIDTH.
- DATA_WIDTH, 32, store data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- mem_wr_en  in  1  ROB head is a ready store
- mem_wr_addr  in  ADDR_WIDTH  store word address
- mem_wr_data  in  DATA_WIDTH  store data
- st_stall  out  1  buffer cannot accept; ROB must hold its head
- dc_wr_req  out  1  write request to the D-cache
- dc_wr_addr  out  ADDR_WIDTH  head entry address
- dc_wr_data  out  DATA_WIDTH  head entry data
- dc_wr_ack  in  1  D-cache has accepted the write this cycle
- ld_valid  in  1  a load is probing for forwarding
- ld_addr  in  ADDR_WIDTH  load word address
- ld_hit  out  1  a buffered store matches ld_addr
- ld_data  out  DATA_WIDTH  data of the youngest matching store
- drained  out  1  buffer empty and no write outstanding

Behaviour:
- Storage: circular FIFO of {addr, data, valid}.
  - wr_ptr and rd_ptr are $clog2(SB_DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Reset (rst_n low at a posedge):
  - Pointers cleared, all valid bits cleared, FSM goes to IDLE.
  - Outputs after reset: st_stall=0, dc_wr_req=0, dc_wr_addr=0, dc_wr_data=0, ld_hit=0, ld_data=0, drained=1.
  - A reset that arrives mid-drain discards every entry, including an unacked request. No ack is awaited afterwards.
- Stall and push:
  - st_stall = full, combinational. It is not relieved by a same-cycle pop.
  - Push happens on mem_wr_en & !st_stall: write the entry at wr_ptr, set valid, increment wr_ptr.
  - mem_wr_en while st_stall is high is ignored. The ROB re-presents the same store.
- Drain FSM:
  - IDLE: dc_wr_req=0. Go to REQ when the buffer is non-empty or a push is accepted this cycle. This gives one cycle of push-to-request latency.
  - REQ: dc_wr_req=1. dc_wr_addr and dc_wr_data are the rd_ptr entry, held stable until ack.
    - On dc_wr_ack: clear the head's valid bit and increment rd_ptr.
    - Stay in REQ if entries remain after the pop, counting any same-cycle push. This allows back-to-back writes at one per ack.
    - Otherwise go to IDLE.
  - dc_wr_ack in IDLE is ignored.
  - In IDLE, dc_wr_addr and dc_wr_data show the head entry, or 0 when empty.
- Push and pop in the same cycle are both performed. The element count is unchanged; both pointers advance.
- Pointer wrap: pointers increment modulo 2*SB_DEPTH. No other wrap handling is needed.
- Forwarding (combinational):
  - Search only entries whose valid bit is set, including the head currently being requested.
  - ld_hit = ld_valid & at least one addr match.
  - ld_data is the youngest match, i.e. the entry closest to wr_ptr-1 walking back to rd_ptr.
  - A store being pushed in the same cycle is not visible.
  - An entry popped by ack is still visible during the ack cycle.
  - ld_data = 0 when there is no hit.
- drained = empty & (state==IDLE).
- Committed stores are architectural. There is no flush input, and branch flushes never touch this block.

Decomposition:
- Add to mips_core_pkg:
  - SB_DEPTH and SB_DEPTH_BITS
  - typedef sb_entry {logic valid; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;}
  - enum sb_state_t {SB_IDLE, SB_REQ}
- One sub-module: store_buffer_fwd_match. It does the purely combinational youngest-first priority search over the entry array, using rd_ptr and wr_ptr.

Test Plan:
- Reset, then push addr 0x10/data 0xAAAA_0001 at cycle 1 -> dc_wr_req=1 at cycle 2 with 0x10/0xAAAA_0001. Ack at cycle 4 -> dc_wr_req=0 at cycle 5 and drained=1.
- Push 4 stores (0x1..0x4) with dc_wr_ack held low -> st_stall=1 after the 4th. A 5th mem_wr_en is held and ignored. Ack once -> st_stall drops next cycle, the 5th push is accepted, and order is preserved.
- Push 0x20/0x11 then 0x20/0x22, then probe ld_addr=0x20 -> ld_hit=1, ld_data=0x22. Probe 0x24 -> ld_hit=0, ld_data=0.
- Ack every cycle while pushing every cycle for 10 stores -> the write stream shows all 10 in order, with pointers wrapping past 2*SB_DEPTH and no loss or duplication.
- Full buffer with ack and push in the same cycle -> push rejected (st_stall=1), head popped, count=3 next cycle.
- Assert rst_n=0 while in REQ with 3 entries -> next cycle dc_wr_req=0, drained=1, and a subsequent ack is ignored.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// Shared types and constants for the store commit buffer.
//
// SB_DEPTH / SB_DEPTH_BITS : default buffer depth and its index width.
// ADDR_WIDTH / DATA_WIDTH  : word address and store data widths. These match the core.
// sb_entry                 : one buffered committed store.
// sb_state_t               : drain FSM states.
package store_commit_buffer_pkg;

   localparam int unsigned SB_DEPTH      = 4;
   localparam int unsigned SB_DEPTH_BITS = $clog2(SB_DEPTH);
   localparam int unsigned ADDR_WIDTH    = 26;
   localparam int unsigned DATA_WIDTH    = 32;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } sb_entry;

   typedef enum logic {
      SB_IDLE,
      SB_REQ
   } sb_state_t;

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bundle of the signals between the store commit buffer and its environment.
//
// ROB side    : mem_wr_en, mem_wr_addr, mem_wr_data (in), st_stall (out)
// D-cache side: dc_wr_req, dc_wr_addr, dc_wr_data (out), dc_wr_ack (in)
// Load probe  : ld_valid, ld_addr (in), ld_hit, ld_data (out)
// Status      : drained (out)
//
// The slave modport is used by the buffer. The master modport is used by the core or bench.
interface store_commit_buffer_if;
   import store_commit_buffer_pkg::*;

   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic                  st_stall;
   logic                  dc_wr_req;
   logic [ADDR_WIDTH-1:0] dc_wr_addr;
   logic [DATA_WIDTH-1:0] dc_wr_data;
   logic                  dc_wr_ack;
   logic                  ld_valid;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic                  ld_hit;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  drained;

   modport slave (
      input  mem_wr_en, mem_wr_addr, mem_wr_data, dc_wr_ack, ld_valid, ld_addr,
      output st_stall, dc_wr_req, dc_wr_addr, dc_wr_data, ld_hit, ld_data, drained
   );

   modport master (
      output mem_wr_en, mem_wr_addr, mem_wr_data, dc_wr_ack, ld_valid, ld_addr,
      input  st_stall, dc_wr_req, dc_wr_addr, dc_wr_data, ld_hit, ld_data, drained
   );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Combinational store-to-load forwarding search over the store buffer entries.
//
// entries  : the buffer entry array (valid/addr/data)
// rd_ptr   : oldest entry pointer (with wrap bit)
// wr_ptr   : next free slot pointer (with wrap bit)
// ld_valid : a load is probing
// ld_addr  : load word address
// ld_hit   : some live entry matches ld_addr
// ld_data  : data of the youngest matching entry, or 0 when there is no hit
module store_buffer_fwd_match
   import store_commit_buffer_pkg::*;
#(
   parameter int unsigned SbDepth = SB_DEPTH
) (
   input  sb_entry [SbDepth-1:0]        entries,
   input  logic    [$clog2(SbDepth):0]  rd_ptr,
   input  logic    [$clog2(SbDepth):0]  wr_ptr,
   input  logic                         ld_valid,
   input  logic    [ADDR_WIDTH-1:0]     ld_addr,
   output logic                         ld_hit,
   output logic    [DATA_WIDTH-1:0]     ld_data
);

   localparam int unsigned IdxW = $clog2(SbDepth);
   localparam int unsigned PtrW = IdxW + 1;

   logic [PtrW-1:0] count;

   assign count = wr_ptr - rd_ptr;

   // Walk from oldest to youngest. A later match overrides an earlier one, so the
   // youngest matching store wins.
   always_comb begin
      logic [IdxW-1:0] idx;
      ld_hit  = 1'b0;
      ld_data = '0;
      idx     = '0;
      for (int unsigned i = 0; i < SbDepth; i++) begin
         idx = rd_ptr[IdxW-1:0] + IdxW'(i);
         if (ld_valid && (PtrW'(i) < count) && entries[idx].valid &&
             (entries[idx].addr == ld_addr)) begin
            ld_hit  = 1'b1;
            ld_data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer. It accepts one retired store per cycle from the ROB, keeps the stores
// in order, drains them to the D-cache over a req/ack handshake, and forwards buffered data
// to probing loads.
//
// clk   : core clock
// rst_n : synchronous active-low reset
// bus   : slave side of store_commit_buffer_if, which carries:
//         mem_wr_en/addr/data, st_stall      (ROB commit port)
//         dc_wr_req/addr/data, dc_wr_ack     (D-cache write port)
//         ld_valid/addr, ld_hit/data         (forwarding probe)
//         drained                            (buffer empty and no write pending)
//
// SbDepth must be a power of two and at least 2. Address and data widths come from the package.
module store_commit_buffer
   import store_commit_buffer_pkg::*;
#(
   parameter int unsigned SbDepth = SB_DEPTH
) (
   input logic                  clk,
   input logic                  rst_n,
   store_commit_buffer_if.slave bus
);

   localparam int unsigned IdxW = $clog2(SbDepth);
   localparam int unsigned PtrW = IdxW + 1;

   sb_entry [SbDepth-1:0] entries_q;
   logic    [PtrW-1:0]    wr_ptr_q;
   logic    [PtrW-1:0]    rd_ptr_q;
   sb_state_t             state_q;
   logic                  req_q;

   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic    [PtrW-1:0]    count;
   logic    [PtrW-1:0]    count_after;
   sb_entry               head;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                  (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

   // The stall comes only from the registered full flag. A pop in the same cycle does not
   // open a slot for the store that is being stalled.
   assign push = bus.mem_wr_en & ~full;
   assign pop  = (state_q == SB_REQ) & bus.dc_wr_ack;

   assign count       = wr_ptr_q - rd_ptr_q;
   assign count_after = count + PtrW'(push) - PtrW'(pop);

   assign head = entries_q[rd_ptr_q[IdxW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entries_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= SB_IDLE;
         req_q     <= 1'b0;
      end else begin
         // Push and pop never target the same slot. That would need the buffer to be
         // both empty and full at once.
         if (push) begin
            entries_q[wr_ptr_q[IdxW-1:0]] <= '{valid: 1'b1,
                                               addr:  bus.mem_wr_addr,
                                               data:  bus.mem_wr_data};
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            entries_q[rd_ptr_q[IdxW-1:0]].valid <= 1'b0;
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end

         unique case (state_q)
            SB_IDLE: begin
               if (!empty || push) begin
                  state_q <= SB_REQ;
                  req_q   <= 1'b1;
               end
            end
            SB_REQ: begin
               // Stay in REQ while entries remain, so the next write follows straight
               // after the ack.
               if (pop && (count_after == '0)) begin
                  state_q <= SB_IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= SB_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.st_stall   = full;
   assign bus.dc_wr_req  = req_q;
   assign bus.dc_wr_addr = head.valid ? head.addr : '0;
   assign bus.dc_wr_data = head.valid ? head.data : '0;
   assign bus.drained    = empty & (state_q == SB_IDLE);

   store_buffer_fwd_match #(
      .SbDepth (SbDepth)
   ) u_fwd_match (
      .entries  (entries_q),
      .rd_ptr   (rd_ptr_q),
      .wr_ptr   (wr_ptr_q),
      .ld_valid (bus.ld_valid),
      .ld_addr  (bus.ld_addr),
      .ld_hit   (bus.ld_hit),
      .ld_data  (bus.ld_data)
   );

   // The D-cache relies on the request payload holding steady until it is acked.
   assert property (@(posedge clk) disable iff (!rst_n)
      (bus.dc_wr_req && !bus.dc_wr_ack) |=>
      (bus.dc_wr_req && $stable(bus.dc_wr_addr) && $stable(bus.dc_wr_data)));

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

   typedef struct packed {
      logic [25:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   wr_t  exp_wr[$];

   store_commit_buffer_if bus ();

   store_commit_buffer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_store(input logic en, input logic [25:0] a, input logic [31:0] d);
      bus.mem_wr_en   = en;
      bus.mem_wr_addr = a;
      bus.mem_wr_data = d;
   endtask

   // Monitor: every accepted D-cache write must be the next expected store.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.dc_wr_req && bus.dc_wr_ack) begin
            total++;
            if (exp_wr.size() == 0) begin
               bad++;
               $display("FAIL wr_stream: unexpected write addr=%0h data=%0h",
                        bus.dc_wr_addr, bus.dc_wr_data);
            end else begin
               e = exp_wr.pop_front();
               if (bus.dc_wr_addr !== e.addr || bus.dc_wr_data !== e.data) begin
                  bad++;
                  $display("FAIL wr_stream: got %0h/%0h expected %0h/%0h",
                           bus.dc_wr_addr, bus.dc_wr_data, e.addr, e.data);
               end
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      drive_store(1'b0, '0, '0);
      bus.dc_wr_ack = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.ld_valid = 1'b1;
      sample();
      chk("rst_st_stall", 32'(bus.st_stall), 32'd0);
      chk("rst_dc_wr_req", 32'(bus.dc_wr_req), 32'd0);
      chk("rst_dc_wr_addr", 32'(bus.dc_wr_addr), 32'd0);
      chk("rst_dc_wr_data", bus.dc_wr_data, 32'd0);
      chk("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
      chk("rst_ld_data", bus.ld_data, 32'd0);
      chk("rst_drained", 32'(bus.drained), 32'd1);
      bus.ld_valid = 1'b0;

      // Single store: request appears one cycle after the push and clears after the ack.
      next();
      drive_store(1'b1, 26'h10, 32'hAAAA_0001);
      exp_wr.push_back('{addr: 26'h10, data: 32'hAAAA_0001});
      next();
      drive_store(1'b0, '0, '0);
      sample();
      chk("t1_req", 32'(bus.dc_wr_req), 32'd1);
      chk("t1_addr", 32'(bus.dc_wr_addr), 32'h10);
      chk("t1_data", bus.dc_wr_data, 32'hAAAA_0001);
      chk("t1_not_drained", 32'(bus.drained), 32'd0);
      next();
      next();
      bus.dc_wr_ack = 1'b1;
      next();
      bus.dc_wr_ack = 1'b0;
      sample();
      chk("t1_req_done", 32'(bus.dc_wr_req), 32'd0);
      chk("t1_drained", 32'(bus.drained), 32'd1);

      // Fill to full, hold a fifth store, and relieve the stall with one ack.
      for (int k = 0; k < 4; k++) begin
         next();
         drive_store(1'b1, 26'(k + 1), 32'(32'hB0 + k));
         exp_wr.push_back('{addr: 26'(k + 1), data: 32'(32'hB0 + k)});
      end
      next();
      drive_store(1'b1, 26'h5, 32'hB4);
      sample();
      chk("t2_full_stall", 32'(bus.st_stall), 32'd1);
      next();
      sample();
      chk("t2_held_stall", 32'(bus.st_stall), 32'd1);
      next();
      bus.dc_wr_ack = 1'b1;
      sample();
      chk("t2_stall_same_cycle_pop", 32'(bus.st_stall), 32'd1);
      next();
      bus.dc_wr_ack = 1'b0;
      exp_wr.push_back('{addr: 26'h5, data: 32'hB4});
      sample();
      chk("t2_stall_relieved", 32'(bus.st_stall), 32'd0);
      next();
      drive_store(1'b0, '0, '0);
      sample();
      chk("t2_refull", 32'(bus.st_stall), 32'd1);
      for (int k = 0; k < 4; k++) begin
         next();
         bus.dc_wr_ack = 1'b1;
      end
      next();
      bus.dc_wr_ack = 1'b0;
      sample();
      chk("t2_drained", 32'(bus.drained), 32'd1);
      chk("t2_req_off", 32'(bus.dc_wr_req), 32'd0);

      // Forwarding: the youngest match wins, and same-cycle pushes are not visible.
      next();
      drive_store(1'b1, 26'h20, 32'h11);
      exp_wr.push_back('{addr: 26'h20, data: 32'h11});
      next();
      drive_store(1'b1, 26'h20, 32'h22);
      exp_wr.push_back('{addr: 26'h20, data: 32'h22});
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 26'h20;
      sample();
      chk("t3_hit_before_push", 32'(bus.ld_hit), 32'd1);
      chk("t3_data_before_push", bus.ld_data, 32'h11);
      next();
      drive_store(1'b0, '0, '0);
      sample();
      chk("t3_hit_youngest", 32'(bus.ld_hit), 32'd1);
      chk("t3_data_youngest", bus.ld_data, 32'h22);
      next();
      bus.ld_addr = 26'h24;
      sample();
      chk("t3_miss_hit", 32'(bus.ld_hit), 32'd0);
      chk("t3_miss_data", bus.ld_data, 32'd0);
      next();
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 26'h20;
      sample();
      chk("t3_no_valid", 32'(bus.ld_hit), 32'd0);
      next();
      bus.ld_valid  = 1'b1;
      bus.dc_wr_ack = 1'b1;
      sample();
      chk("t3_data_during_pop1", bus.ld_data, 32'h22);
      next();
      sample();
      chk("t3_hit_during_pop2", 32'(bus.ld_hit), 32'd1);
      chk("t3_data_during_pop2", bus.ld_data, 32'h22);
      next();
      bus.dc_wr_ack = 1'b0;
      sample();
      chk("t3_hit_after_pop", 32'(bus.ld_hit), 32'd0);
      chk("t3_drained", 32'(bus.drained), 32'd1);
      bus.ld_valid = 1'b0;

      // Streaming: push and ack every cycle, so the pointers wrap.
      for (int k = 0; k < 10; k++) begin
         next();
         drive_store(1'b1, 26'(26'h100 + k), 32'(32'hC000 + k));
         exp_wr.push_back('{addr: 26'(26'h100 + k), data: 32'(32'hC000 + k)});
         bus.dc_wr_ack = 1'b1;
         sample();
         chk("t4_no_stall", 32'(bus.st_stall), 32'd0);
      end
      next();
      drive_store(1'b0, '0, '0);
      next();
      bus.dc_wr_ack = 1'b0;
      sample();
      chk("t4_drained", 32'(bus.drained), 32'd1);

      // Reset during REQ discards every entry, including the pending request.
      for (int k = 0; k < 3; k++) begin
         next();
         drive_store(1'b1, 26'(26'h200 + k), 32'(32'hD000 + k));
         exp_wr.push_back('{addr: 26'(26'h200 + k), data: 32'(32'hD000 + k)});
      end
      next();
      drive_store(1'b0, '0, '0);
      sample();
      chk("t6_req_before_rst", 32'(bus.dc_wr_req), 32'd1);
      chk("t6_head_before_rst", 32'(bus.dc_wr_addr), 32'h200);
      next();
      rst_n = 1'b0;
      exp_wr.delete();
      next();
      rst_n = 1'b1;
      sample();
      chk("t6_req_after_rst", 32'(bus.dc_wr_req), 32'd0);
      chk("t6_drained_after_rst", 32'(bus.drained), 32'd1);
      chk("t6_addr_after_rst", 32'(bus.dc_wr_addr), 32'd0);
      chk("t6_stall_after_rst", 32'(bus.st_stall), 32'd0);
      next();
      bus.dc_wr_ack = 1'b1;
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 26'h201;
      sample();
      chk("t6_no_fwd_after_rst", 32'(bus.ld_hit), 32'd0);
      next();
      bus.dc_wr_ack = 1'b0;
      bus.ld_valid  = 1'b0;
      sample();
      chk("t6_req_after_ack", 32'(bus.dc_wr_req), 32'd0);
      chk("t6_drained_after_ack", 32'(bus.drained), 32'd1);

      chk("sb_all_writes_seen", 32'(exp_wr.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
